// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream multiplexer.
// Imported by the interface, the grant encoder and the top level.
package stream_mux_pkg;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Index width for n channels, never less than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Producer/consumer bundle of the stream multiplexer.
// master drives the streams, slave is the multiplexer itself.
interface stream_mux_if
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 8
);

    localparam int SEL_W = sel_width(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output mode,
        output sel,
        input  out_data,
        input  out_ch,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  mode,
        input  sel,
        output out_data,
        output out_ch,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/stream_mux_rr_grant.sv
// Rotating-priority encoder: first set request at or after ptr,
// wrapping modulo NUM_CH.
module rr_grant
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 8,
    localparam int SEL_W = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt,
    output logic              gnt_valid
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        idx       = ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt       = idx;
            end
            idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux.sv
// Registered NUM_CH:1 stream multiplexer, direct-select or
// round-robin, with a one-entry output register.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    stream_mux_if.slave  bus
);

    localparam int SEL_W = sel_width(NUM_CH);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              vld_q, vld_d;

    logic [SEL_W-1:0]  rr_gnt;
    logic              rr_vld;
    logic [SEL_W-1:0]  gnt;
    logic              gnt_act;
    logic              sel_vld;
    logic              load_en;
    logic              xfer;
    logic [WIDTH-1:0]  word;
    logic [NUM_CH-1:0] rdy;

    rr_grant #(
        .NUM_CH (NUM_CH)
    ) u_rr_grant (
        .req       (bus.in_valid),
        .ptr       (ptr_q),
        .gnt       (rr_gnt),
        .gnt_valid (rr_vld)
    );

    // Out-of-range sel matches no channel, so it never grants.
    always_comb begin
        sel_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                sel_vld = bus.in_valid[i];
            end
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_act = 1'b0;
        unique case (bus.mode)
            MODE_SELECT: begin
                gnt     = bus.sel;
                gnt_act = sel_vld;
            end
            MODE_RR: begin
                gnt     = rr_gnt;
                gnt_act = rr_vld;
            end
        endcase
    end

    assign load_en = !vld_q || bus.out_ready;
    assign xfer    = gnt_act && load_en;

    always_comb begin
        rdy  = '0;
        word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == SEL_W'(i)) begin
                rdy[i] = xfer;
                word   = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A load in the same cycle as a drain replaces the word: no bubble.
    always_comb begin
        ptr_d  = ptr_q;
        data_d = data_q;
        ch_d   = ch_q;
        vld_d  = vld_q;
        if (xfer) begin
            data_d = word;
            ch_d   = gnt;
            vld_d  = 1'b1;
            ptr_d  = (gnt == LAST) ? '0 : gnt + 1'b1;
        end else if (bus.out_ready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            data_q <= '0;
            ch_q   <= '0;
            vld_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            data_q <= data_d;
            ch_q   <= ch_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = vld_q;

    a_rdy_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(rdy)
    );

    a_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        vld_q && !bus.out_ready |=>
            vld_q && $stable(data_q) && $stable(ch_q)
    );

endmodule

// File: tb/tb_stream_mux.sv
// Scoreboard bench for stream_mux, NUM_CH = 8, WIDTH = 8.
// Directed scenarios plus a cycle model checked every cycle.
module tb_stream_mux;

    localparam int N = 8;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   ch;
    } word_t;

    logic clk;
    logic rst_n;

    stream_mux_if #(.NUM_CH(N), .WIDTH(W)) bus ();

    stream_mux #(.NUM_CH(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    word_t        exp_q[$];
    logic         m_vld   = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic [2:0]   m_ch    = '0;
    int           m_ptr   = 0;
    logic         m_drain = 1'b0;

    // Inputs only change just after posedge, so negedge sees what
    // the next posedge will act on.
    always @(negedge clk) begin
        int           g;
        logic         found;
        logic         load;
        logic [N-1:0] exp_rdy;
        word_t        w;
        if (!rst_n) begin
            exp_q.delete();
            m_vld   = 1'b0;
            m_ptr   = 0;
            m_drain = 1'b0;
            chk("rst_valid", 32'(bus.out_valid), 32'd0);
        end else begin
            if (exp_q.size() > 0) begin
                w      = exp_q.pop_front();
                m_vld  = 1'b1;
                m_data = w.data;
                m_ch   = w.ch;
            end else if (m_drain) begin
                m_vld = 1'b0;
            end
            chk("sb_valid", 32'(bus.out_valid), 32'(m_vld));
            if (m_vld) begin
                chk("sb_data", 32'(bus.out_data), 32'(m_data));
                chk("sb_ch", 32'(bus.out_ch), 32'(m_ch));
            end
            g     = 0;
            found = 1'b0;
            if (bus.mode == 1'b0) begin
                g     = int'(bus.sel);
                found = (g < N) && bus.in_valid[g];
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!found && bus.in_valid[(m_ptr + k) % N]) begin
                        found = 1'b1;
                        g     = (m_ptr + k) % N;
                    end
                end
            end
            load    = !m_vld || bus.out_ready;
            exp_rdy = '0;
            m_drain = 1'b0;
            if (found && load) begin
                exp_rdy[g] = 1'b1;
                w.ch   = 3'(g);
                w.data = bus.in_data[g*W +: W];
                exp_q.push_back(w);
                m_ptr  = (g + 1) % N;
            end else begin
                m_drain = m_vld && bus.out_ready;
            end
            chk("sb_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;
        bus.in_valid  = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_data[i*W +: W] = 8'hA0 + 8'(i);
        end
        repeat (2) cyc();
        chk("reset_ready", 32'(bus.in_ready), 32'd0);
        chk("reset_data", 32'(bus.out_data), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Direct-select walk
        bus.in_valid  = '1;
        bus.out_ready = 1'b1;
        for (int s = 0; s < N; s++) begin
            bus.sel = 3'(s);
            cyc();
            chk("walk_data", 32'(bus.out_data), 32'(8'hA0 + 8'(s)));
            chk("walk_ch", 32'(bus.out_ch), 32'(s));
        end

        // Backpressure: A7/ch7 must hold for three cycles
        bus.out_ready = 1'b0;
        bus.sel       = 3'd3;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_data", 32'(bus.out_data), 32'hA7);
            chk("bp_ch", 32'(bus.out_ch), 32'd7);
            chk("bp_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'h08);
        cyc();
        chk("bp_next_data", 32'(bus.out_data), 32'hA3);
        chk("bp_next_valid", 32'(bus.out_valid), 32'd1);

        // Reset mid-burst, then round-robin fairness from ptr 0
        bus.mode = 1'b1;
        cyc();
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        chk("rst_ptr", 32'(dut.ptr_q), 32'd0);
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k <= N; k++) begin
            cyc();
            chk("rr_ch", 32'(bus.out_ch), 32'(k % N));
        end

        // Sparse round-robin from ptr 3
        bus.mode = 1'b0;
        bus.sel  = 3'd2;
        cyc();
        chk("sparse_setup_ptr", 32'(dut.ptr_q), 32'd3);
        bus.mode     = 1'b1;
        bus.in_valid = 8'b0010_0100;
        cyc();
        chk("sparse_1", 32'(bus.out_ch), 32'd5);
        cyc();
        chk("sparse_2", 32'(bus.out_ch), 32'd2);
        cyc();
        chk("sparse_3", 32'(bus.out_ch), 32'd5);
        bus.in_valid = '0;
        cyc();
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("idle_ptr", 32'(dut.ptr_q), 32'd6);

        // Mode switch fairness
        bus.in_valid = '1;
        bus.mode     = 1'b0;
        bus.sel      = 3'd6;
        cyc();
        chk("switch_sel", 32'(bus.out_ch), 32'd6);
        bus.mode = 1'b1;
        cyc();
        chk("switch_rr", 32'(bus.out_ch), 32'd7);
        chk("switch_data", 32'(bus.out_data), 32'hA7);

        bus.in_valid = '0;
        repeat (3) cyc();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised, registered N-channel stream multiplexer with valid/ready handshaking. It is the next generation of the team's combinational 8:1 single-bit multiplexer, generalised to NUM_CH channels of WIDTH bits each. It adds two selection modes, direct select and round-robin arbitration, plus a one-entry output register. It sits between several producer streams and a single consumer, for example a shared bus or a serialiser.

## Interface
- NUM_CH, 8, number of input channels (≥2)
- WIDTH, 8, data bits per channel (≥1)
- SEL_W, derived = max(1, clog2(NUM_CH)); not overridable

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NUM_CH  per-channel valid
- in_ready  out  NUM_CH  per-channel ready (combinational)
- mode  in  1  0 = direct select, 1 = round-robin
- sel  in  SEL_W  channel index used in mode 0
- out_data  out  WIDTH  registered data
- out_ch  out  SEL_W  index of the channel that supplied out_data
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accepts the word

## Operation
- Output register:
  - Single entry holding out_data, out_ch and out_valid.
  - load_en = !out_valid | out_ready.
- Grant logic (combinational, evaluated each cycle):
  - Mode 0:
    - gnt = sel.
    - Grant is active when in_valid[sel] is set.
    - A sel value ≥ NUM_CH grants nothing and leaves all in_ready at 0.
  - Mode 1:
    - Search in_valid starting at channel ptr, then ptr+1, and so on, wrapping modulo NUM_CH.
    - The first valid channel wins.
    - No valid channel means no grant.
- in_ready[gnt] = load_en & grant-active. Every other in_ready bit is 0.
  - At most one in_ready bit is high in any cycle.
- Transfer on a channel occurs when in_valid[i] & in_ready[i].
  - On a transfer: out_data ← channel data, out_ch ← i, out_valid ← 1.
- Drain with no new transfer (out_valid & out_ready): out_valid ← 0.
- Round-robin pointer ptr (SEL_W bits):
  - On every transfer, ptr ← (gnt+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
  - The update also happens when the transfer occurs in mode 0, so that a later switch to mode 1 stays fair.
  - ptr holds when there is no transfer.
- Output stability: while out_valid & !out_ready, out_data and out_ch hold steady and out_valid stays 1.
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0. in_ready follows from these, so it is 1 only for a granted valid channel.
- Reset mid-operation:
  - Reset takes effect immediately and asynchronously.
  - A word pending in the register is discarded.
  - The pointer returns to 0.

## Timing
- Latency: a word transferred in cycle n appears with out_valid = 1 in cycle n+1.
- Throughput: one word per cycle while out_ready is held at 1.
- in_ready depends combinationally on out_ready, out_valid, in_valid, mode, sel and ptr.
  - No combinational path from any in_data bit to any output.
- Simultaneous drain and load in one cycle: the new word replaces the old one and out_valid stays 1, so there is no bubble.
- Changes to mode or sel take effect in the same cycle's grant. No state is flushed when they change.
- Producers must hold in_valid and in_data steady until their transfer completes. The block does not check this.

## Structure
- Shared package stream_mux_pkg:
  - Mode constants MODE_SELECT = 1'b0 and MODE_RR = 1'b1.
  - A clog2-style function used to derive SEL_W.
- One sub-module, rr_grant:
  - Combinational rotating-priority encoder.
  - Parameter NUM_CH.
  - Inputs: req[NUM_CH], ptr[SEL_W]. Outputs: gnt[SEL_W], gnt_valid.
- Top level holds the output register, the ptr register and the mode-0/mode-1 grant selection.

## Test plan
- Reset: assert rst_n = 0 mid-burst with out_valid = 1 → out_valid, out_data, out_ch and ptr are 0 immediately; the first transfer after release comes from channel 0 in mode 1.
- Mode 0 walk, NUM_CH = 8, WIDTH = 8:
  - Channel i data = 8'hA0+i, all valid, out_ready = 1.
  - Step sel through 0..7.
  - Each cycle out_data = A0+sel and out_ch = sel one cycle later; no other in_ready bit is high.
- Backpressure: out_ready = 0 for 3 cycles with a word held → out_data and out_ch stable, all in_ready = 0; out_ready = 1 → next word loads in the same cycle with no bubble.
- Round-robin fairness, mode 1, all 8 valid, out_ready = 1 → out_ch sequence 0,1,…,7,0, i.e. ptr wraps from 7 to 0.
- Sparse round-robin:
  - Only channels 2 and 5 valid, ptr = 3 → grants 5, then 2, then 5.
  - No valid channels → out_valid drops after the drain and ptr holds.
- Mode switch: transfer from sel = 6 in mode 0, then switch to mode 1 with all channels valid → next grant is channel 7.
